// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port sdram_cntl host arbiter.
package sdram_arb_pkg;

    localparam int SDRAM_ADDR_W = 24;
    localparam int SDRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/sdram_arb_rr2.sv
// Two-way round-robin picker: combinational grant selection plus the priority
// pointer, which moves to the non-owner whenever an operation finishes.
module sdram_arb_rr2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    input  logic       owner_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = ~owner_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // The pointer only matters when both ports contend.
    always_comb begin
        gnt_valid_o = |req_i;
        case (req_i)
            2'b01:   gnt_idx_o = 1'b0;
            2'b10:   gnt_idx_o = 1'b1;
            2'b11:   gnt_idx_o = ptr_q;
            default: gnt_idx_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/sdram_host_arb.sv
// Shares one sdram_cntl host port between two requesters, round-robin, with a
// per-operation timeout that aborts a strobe the controller never answers.
module sdram_host_arb
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = SDRAM_ADDR_W,
    parameter int DATA_W      = SDRAM_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_rd_i,
    input  logic              m0_wr_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_done_o,
    output logic              m0_err_o,

    input  logic              m1_rd_i,
    input  logic              m1_wr_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_done_o,
    output logic              m1_err_o,

    output logic              host_rd_o,
    output logic              host_wr_o,
    output logic [ADDR_W-1:0] host_addr_o,
    output logic [DATA_W-1:0] host_data_o,
    input  logic [DATA_W-1:0] host_data_i,
    input  logic              host_done_i,

    output logic              busy_o,
    output logic              grant_o,
    output state_e            dbg_state_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    state_e            state_q;
    op_e               op_q;
    logic              grant_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              host_rd_q;
    logic              host_wr_q;
    logic [ADDR_W-1:0] host_addr_q;
    logic [DATA_W-1:0] host_data_q;
    logic              busy_q;
    logic [DATA_W-1:0] m0_data_q;
    logic [DATA_W-1:0] m1_data_q;
    logic              m0_done_q;
    logic              m1_done_q;
    logic              m0_err_q;
    logic              m1_err_q;

    logic              gnt_valid;
    logic              gnt_idx;
    logic              sel_wr_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_data_d;
    logic              done_hit_d;
    logic              to_hit_d;

    sdram_arb_rr2 u_rr2 (
        .clk         (clk),
        .rst         (rst),
        .req_i       ({m1_rd_i | m1_wr_i, m0_rd_i | m0_wr_i}),
        .adv_i       (done_hit_d | to_hit_d),
        .owner_i     (grant_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // rd and wr together from one port is treated as a write.
    always_comb begin
        sel_wr_d   = gnt_idx ? m1_wr_i   : m0_wr_i;
        sel_addr_d = gnt_idx ? m1_addr_i : m0_addr_i;
        sel_data_d = gnt_idx ? m1_data_i : m0_data_i;
        done_hit_d = (state_q == ISSUE) && host_done_i;
        to_hit_d   = TO_EN && (state_q == ISSUE) && !host_done_i && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            grant_q     <= 1'b0;
            cnt_q       <= '0;
            host_rd_q   <= 1'b0;
            host_wr_q   <= 1'b0;
            host_addr_q <= '0;
            host_data_q <= '0;
            busy_q      <= 1'b0;
            m0_data_q   <= '0;
            m1_data_q   <= '0;
            m0_done_q   <= 1'b0;
            m1_done_q   <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
        end else begin
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
            m0_err_q  <= 1'b0;
            m1_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        state_q     <= ISSUE;
                        busy_q      <= 1'b1;
                        grant_q     <= gnt_idx;
                        cnt_q       <= '0;
                        op_q        <= sel_wr_d ? OP_WR : OP_RD;
                        host_rd_q   <= ~sel_wr_d;
                        host_wr_q   <= sel_wr_d;
                        host_addr_q <= sel_addr_d;
                        host_data_q <= sel_data_d;
                    end
                end
                ISSUE: begin
                    if (done_hit_d) begin
                        state_q   <= RESP;
                        host_rd_q <= 1'b0;
                        host_wr_q <= 1'b0;
                        if (grant_q) begin
                            m1_done_q <= 1'b1;
                            if (op_q == OP_RD) m1_data_q <= host_data_i;
                        end else begin
                            m0_done_q <= 1'b1;
                            if (op_q == OP_RD) m0_data_q <= host_data_i;
                        end
                    end else if (to_hit_d) begin
                        state_q   <= RESP;
                        host_rd_q <= 1'b0;
                        host_wr_q <= 1'b0;
                        if (grant_q) begin
                            m1_done_q <= 1'b1;
                            m1_err_q  <= 1'b1;
                        end else begin
                            m0_done_q <= 1'b1;
                            m0_err_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    host_rd_q <= 1'b0;
                    host_wr_q <= 1'b0;
                end
            endcase
        end
    end

    assign m0_data_o   = m0_data_q;
    assign m0_done_o   = m0_done_q;
    assign m0_err_o    = m0_err_q;
    assign m1_data_o   = m1_data_q;
    assign m1_done_o   = m1_done_q;
    assign m1_err_o    = m1_err_q;
    assign host_rd_o   = host_rd_q;
    assign host_wr_o   = host_wr_q;
    assign host_addr_o = host_addr_q;
    assign host_data_o = host_data_q;
    assign busy_o      = busy_q;
    assign grant_o     = grant_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sdram_host_arb.sv
// Directed bench for sdram_host_arb; the bench itself plays the sdram_cntl side.
module tb_sdram_host_arb;
    import sdram_arb_pkg::*;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_rd_i, m0_wr_i, m1_rd_i, m1_wr_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_data_i, m1_data_i;
    logic [DW-1:0] m0_data_o, m1_data_o;
    logic          m0_done_o, m0_err_o, m1_done_o, m1_err_o;
    logic          host_rd_o, host_wr_o;
    logic [AW-1:0] host_addr_o;
    logic [DW-1:0] host_data_o;
    logic [DW-1:0] host_data_i;
    logic          host_done_i;
    logic          busy_o, grant_o;
    state_e        dbg_state_o;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    sdram_host_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_rd_i(m0_rd_i), .m0_wr_i(m0_wr_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
        .m0_data_o(m0_data_o), .m0_done_o(m0_done_o), .m0_err_o(m0_err_o),
        .m1_rd_i(m1_rd_i), .m1_wr_i(m1_wr_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_data_o(m1_data_o), .m1_done_o(m1_done_o), .m1_err_o(m1_err_o),
        .host_rd_o(host_rd_o), .host_wr_o(host_wr_o), .host_addr_o(host_addr_o),
        .host_data_o(host_data_o), .host_data_i(host_data_i), .host_done_i(host_done_i),
        .busy_o(busy_o), .grant_o(grant_o), .dbg_state_o(dbg_state_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controller model: waits for a strobe, answers done on the lat-th strobe
    // cycle (lat=0 never answers) and returns in the cycle after the strobe drops.
    task automatic serve(input int lat, input logic [DW-1:0] rdata,
                         output int waited, output int hi, output logic wr_seen,
                         output logic [AW-1:0] addr_seen, output logic [DW-1:0] data_seen,
                         output logic stable);
        waited = 0; hi = 0; wr_seen = 1'b0; addr_seen = '0; data_seen = '0; stable = 1'b1;
        while (!(host_rd_o || host_wr_o) && waited < 50) begin
            tick();
            waited++;
        end
        wr_seen   = host_wr_o;
        addr_seen = host_addr_o;
        data_seen = host_data_o;
        while ((host_rd_o || host_wr_o) && hi < 400) begin
            hi++;
            if (host_addr_o !== addr_seen || host_data_o !== data_seen || host_wr_o !== wr_seen)
                stable = 1'b0;
            if (hi == lat) begin
                host_done_i = 1'b1;
                host_data_i = rdata;
            end
            tick();
            host_done_i = 1'b0;
            host_data_i = DW'($urandom);
        end
    endtask

    initial begin
        int            w, h;
        logic          ws, st;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          exp_owner;

        rst = 1'b1;
        m0_rd_i = 0; m0_wr_i = 0; m1_rd_i = 0; m1_wr_i = 0;
        m0_addr_i = '0; m1_addr_i = '0; m0_data_i = '0; m1_data_i = '0;
        host_data_i = '0; host_done_i = 1'b0;
        repeat (3) tick();

        chk("rst_host_rd", 32'(host_rd_o), 32'(0));
        chk("rst_host_wr", 32'(host_wr_o), 32'(0));
        chk("rst_host_addr", 32'(host_addr_o), 32'(0));
        chk("rst_done", 32'({m0_done_o, m1_done_o, m0_err_o, m1_err_o}), 32'(0));
        chk("rst_data", 32'({m0_data_o, m1_data_o}), 32'(0));
        chk("rst_busy_grant", 32'({busy_o, grant_o}), 32'(0));
        chk("rst_state", 32'(dbg_state_o), 32'(IDLE));
        rst = 1'b0;
        tick();

        // Stray done while idle is ignored.
        host_done_i = 1'b1; host_data_i = 16'hDEAD;
        tick();
        host_done_i = 1'b0;
        chk("stray_done", 32'({m0_done_o, m1_done_o, busy_o, host_rd_o}), 32'(0));
        chk("stray_data", 32'(m0_data_o), 32'(0));

        // Single read from m0.
        m0_rd_i = 1'b1; m0_addr_i = 24'h000123;
        serve(5, 16'hBEEF, w, h, ws, a, d, st);
        chk("t1_latency", 32'(w), 32'(1));
        chk("t1_strobe_len", 32'(h), 32'(5));
        chk("t1_is_read", 32'(ws), 32'(0));
        chk("t1_addr", 32'(a), 32'h000123);
        chk("t1_stable", 32'(st), 32'(1));
        chk("t1_done_err", 32'({m0_done_o, m0_err_o}), 32'(2'b10));
        chk("t1_rdata", 32'(m0_data_o), 32'hBEEF);
        chk("t1_m1_quiet", 32'({m1_done_o, m1_err_o, m1_data_o}), 32'(0));
        chk("t1_grant", 32'(grant_o), 32'(0));
        m0_rd_i = 1'b0;
        tick();
        chk("t1_done_one_pulse", 32'(m0_done_o), 32'(0));
        chk("t1_busy_idle", 32'(busy_o), 32'(0));

        // Simultaneous requests after reset: m0 first, then re-contention favours m1.
        rst = 1'b1; tick(); rst = 1'b0;
        m0_wr_i = 1'b1; m0_addr_i = 24'h000010; m0_data_i = 16'hA5A5;
        m1_rd_i = 1'b1; m1_addr_i = 24'h000020;
        serve(3, 16'h1111, w, h, ws, a, d, st);
        chk("t2a_grant", 32'(grant_o), 32'(0));
        chk("t2a_is_write", 32'(ws), 32'(1));
        chk("t2a_addr", 32'(a), 32'h000010);
        chk("t2a_wdata", 32'(d), 32'hA5A5);
        chk("t2a_done", 32'({m0_done_o, m1_done_o}), 32'(2'b10));
        chk("t2a_m0_data_hold", 32'(m0_data_o), 32'(0));
        m0_wr_i = 1'b0;
        tick();
        m0_wr_i = 1'b1;
        serve(3, 16'h2222, w, h, ws, a, d, st);
        chk("t2b_grant", 32'(grant_o), 32'(1));
        chk("t2b_latency", 32'(w), 32'(1));
        chk("t2b_addr", 32'(a), 32'h000020);
        chk("t2b_done", 32'({m0_done_o, m1_done_o}), 32'(2'b01));
        chk("t2b_rdata", 32'(m1_data_o), 32'h2222);
        m1_rd_i = 1'b0;
        serve(3, 16'h3333, w, h, ws, a, d, st);
        chk("t2c_grant", 32'(grant_o), 32'(0));
        chk("t2c_done", 32'({m0_done_o, m1_done_o}), 32'(2'b10));
        m0_wr_i = 1'b0;
        tick();

        // Continuous contention: 20 operations per port, strictly alternating.
        rst = 1'b1; tick(); rst = 1'b0;
        m0_wr_i = 1'b1; m0_addr_i = 24'h000100; m0_data_i = 16'hC0DE;
        m1_rd_i = 1'b1; m1_addr_i = 24'h000200;
        exp_owner = 1'b0;
        for (int i = 0; i < 40; i++) begin
            serve(2, 16'(16'h3000 + i), w, h, ws, a, d, st);
            chk("t3_grant", 32'(grant_o), 32'(exp_owner));
            chk("t3_strobe_len", 32'(h), 32'(2));
            chk("t3_done", 32'({m0_done_o, m1_done_o}), exp_owner ? 32'(2'b01) : 32'(2'b10));
            if (exp_owner) begin
                chk("t3_m1_rdata", 32'(m1_data_o), 32'(16'h3000 + i));
                m1_rd_i = 1'b0;
            end else begin
                m0_wr_i = 1'b0;
            end
            tick();
            if (exp_owner) m1_rd_i = 1'b1;
            else           m0_wr_i = 1'b1;
            exp_owner = ~exp_owner;
        end
        m0_wr_i = 1'b0; m1_rd_i = 1'b0;
        // One request may already be latched from the last re-raise; let it drain.
        tick();
        serve(1, 16'h0000, w, h, ws, a, d, st);
        tick();

        // Timeout on an m1 write: strobe for exactly TO cycles, done+err together.
        m1_wr_i = 1'b1; m1_addr_i = 24'h000040; m1_data_i = 16'h7777;
        serve(0, 16'h0000, w, h, ws, a, d, st);
        chk("t4_strobe_len", 32'(h), 32'(TO));
        chk("t4_is_write", 32'(ws), 32'(1));
        chk("t4_done_err", 32'({m1_done_o, m1_err_o}), 32'(2'b11));
        chk("t4_m0_quiet", 32'({m0_done_o, m0_err_o}), 32'(0));
        chk("t4_data_hold", 32'(m1_data_o), 32'h3027);
        m1_wr_i = 1'b0;
        tick();
        chk("t4_err_one_pulse", 32'({m1_done_o, m1_err_o}), 32'(0));

        // Done on the final timeout cycle: done wins, no error, data captured.
        m1_rd_i = 1'b1; m1_addr_i = 24'h000050;
        serve(TO, 16'h5A5A, w, h, ws, a, d, st);
        chk("t5_strobe_len", 32'(h), 32'(TO));
        chk("t5_done_err", 32'({m1_done_o, m1_err_o}), 32'(2'b10));
        chk("t5_rdata", 32'(m1_data_o), 32'h5A5A);
        m1_rd_i = 1'b0;
        tick();

        // m0 completes so the pointer favours m1, then reset lands mid-ISSUE.
        m0_wr_i = 1'b1;
        serve(1, 16'h0000, w, h, ws, a, d, st);
        m0_wr_i = 1'b0;
        tick();
        m1_rd_i = 1'b1; m1_addr_i = 24'h000060;
        w = 0;
        while (!host_rd_o && w < 50) begin
            tick();
            w++;
        end
        chk("t6_strobe_seen", 32'(host_rd_o), 32'(1));
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t6_strobe_low", 32'({host_rd_o, host_wr_o}), 32'(0));
        chk("t6_no_done", 32'({m0_done_o, m1_done_o, m0_err_o, m1_err_o}), 32'(0));
        chk("t6_data_clear", 32'({m0_data_o, m1_data_o}), 32'(0));
        chk("t6_busy", 32'(busy_o), 32'(0));
        rst = 1'b0; m0_rd_i = 1'b1; m0_addr_i = 24'h000070;
        serve(2, 16'h6666, w, h, ws, a, d, st);
        chk("t6_m0_first", 32'(grant_o), 32'(0));
        chk("t6_m0_rdata", 32'(m0_data_o), 32'h6666);
        m0_rd_i = 1'b0;
        serve(2, 16'h7777, w, h, ws, a, d, st);
        chk("t6_m1_next", 32'(grant_o), 32'(1));
        chk("t6_m1_rdata", 32'(m1_data_o), 32'h7777);
        m1_rd_i = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdram_host_arb.md
Name: sdram_host_arb

Overview:
Two-port round-robin arbiter that shares the single sdram_cntl host interface between two requesters, for example a CPU-side port and a DMA/video port.
- Latches the winning request and drives the controller strobe until done.
- Returns read data and a done pulse to the owning requester.
- Guards against a hung controller with a per-operation timeout.
- Sits between the requesters and sdram_cntl; shares clk and the active-high reset with the myreset output.

Parameters:
ADDR_W, 24, host address width (matches sdram_cntl)
DATA_W, 16, host data width
TIMEOUT_CYC, 255, max cycles strobe held awaiting done; 0 disables timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
m0_rd_i  in  1  requester 0 read request, level, held until m0_done_o
m0_wr_i  in  1  requester 0 write request, level, held until m0_done_o
m0_addr_i  in  ADDR_W  requester 0 address
m0_data_i  in  DATA_W  requester 0 write data
m0_data_o  out  DATA_W  requester 0 last read data
m0_done_o  out  1  requester 0 completion pulse
m0_err_o  out  1  requester 0 timeout pulse, coincident with done
m1_*  same set as m0_* for requester 1
host_rd_o  out  1  read strobe to sdram_cntl
host_wr_o  out  1  write strobe to sdram_cntl
host_addr_o  out  ADDR_W  address to sdram_cntl
host_data_o  out  DATA_W  write data to sdram_cntl
host_data_i  in  DATA_W  read data from sdram_cntl, valid with host_done_i
host_done_i  in  1  completion from sdram_cntl
busy_o  out  1  high whenever state != IDLE
grant_o  out  1  owner of current/last operation (0 = m0)

Behaviour:
- Reset: all outputs 0; state IDLE; priority pointer favours m0; timeout counter 0.
- All outputs are registered.
- States:
  - IDLE: sample requests (reqX = mX_rd_i | mX_wr_i).
    - No request: stay in IDLE.
    - Single request: grant it.
    - Both requesting: grant the pointer's favourite.
    - On grant: register grant_o, addr, wdata, op → ISSUE.
  - ISSUE: host_rd_o or host_wr_o held high with stable addr/data.
    - host_done_i=1 → RESP.
    - Counter reaches TIMEOUT_CYC without done → RESP with error.
  - RESP: one cycle; pulse mX_done_o for the owner; mX_err_o=1 if timed out; then → IDLE.
- Latency:
  - Request sampled in IDLE at cycle N → host strobe high at N+1.
  - host_done_i at cycle M → strobe low, mX_done_o high, read data visible on mX_data_o at M+1.
  - IDLE resumes at M+2; earliest next strobe is M+3.
- Requester must drop its request by the cycle after its done pulse.
- Priority: after each completed or timed-out operation, the pointer moves to the non-owner.
- rd and wr both high from one requester: treated as write.
- mX_data_o updates only on a successful read completion of that requester; holds otherwise, including across timeouts and writes.
- Timeout: counter clears on ISSUE entry and increments each ISSUE cycle without done. The strobe is high for exactly TIMEOUT_CYC cycles before abort.
- Done in the same cycle as timeout expiry: done wins, no err.
- host_done_i outside ISSUE: ignored.
- Requester dropping its request mid-ISSUE: the operation still completes and the done pulse is still emitted.
- rst mid-operation: strobes low the next cycle, no done/err pulse, pointer back to m0, mX_data_o cleared.

Decomposition:
- Package sdram_arb_pkg holds:
  - state enum {IDLE, ISSUE, RESP};
  - default ADDR_W/DATA_W constants;
  - op encoding (OP_RD, OP_WR).
- One sub-module sdram_arb_rr2: 2-way round-robin picker (req[1:0], pointer → grant), combinational plus pointer register. The FSM and datapath stay in the top.

Test Plan:
- Single read: m0_rd_i, addr 0x000123; model returns 0xBEEF with done 5 cycles after strobe → host_rd_o high 5 cycles, m0_done_o one pulse, m0_data_o=0xBEEF, m1 outputs untouched.
- Simultaneous requests after reset: m0 write 0x0010/0xA5A5 and m1 read 0x0020 both held → m0 served first, then m1. Repeat both → m1 first.
- Continuous contention, 20 operations per port → grants strictly alternate; no double issue of the same request.
- Timeout with TIMEOUT_CYC=16, model never asserts done on an m1 write → host_wr_o high exactly 16 cycles; m1_done_o and m1_err_o pulse together; m1_data_o unchanged.
- Done coincident with final timeout cycle → done pulse, err=0, read data captured.
- rst asserted 3 cycles into ISSUE → strobe low next cycle, no done pulse. After release, m1 and m0 requesting together → m0 granted.
